// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage load/store unit:
// sequencer states, bus widths and address helpers.
package mem_stage_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int MEM_BYTES_DEF = 72;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_ISSUE   = 3'd1,
        RD_CAPT    = 3'd2,
        WR         = 3'd3,
        RESP_FAULT = 3'd4
    } lsu_state_e;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

    // last_byte is the highest legal byte address; a word needs last_byte too.
    function automatic logic access_fault(input logic [ADDR_W-1:0] addr,
                                          input logic              is_byte,
                                          input logic [ADDR_W-1:0] last_byte);
        logic flt;
        if (is_byte) begin
            flt = (addr > last_byte);
        end else begin
            flt = addr[0] | (addr >= last_byte);
        end
        return flt;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte lane for a big-endian 16-bit word: selects/extends a byte for loads
// and splices a new byte into the read word for read-modify-write stores.
module lsu_byte_lane
    import mem_stage_pkg::*;
#(
    parameter int BYTE_SEXT = 0
) (
    input  logic              lane_sel_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [7:0]        wbyte_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] merge_data_o
);

    logic [7:0] sel_byte_s;

    // Even address is the high byte of the word.
    always_comb begin
        sel_byte_s = 8'h00;
        if (lane_sel_i) begin
            sel_byte_s = rdata_i[7:0];
        end else begin
            sel_byte_s = rdata_i[15:8];
        end
    end

    // Load extension of the selected byte.
    always_comb begin
        load_data_o = 16'h0000;
        if (BYTE_SEXT != 0) begin
            load_data_o = {{8{sel_byte_s[7]}}, sel_byte_s};
        end else begin
            load_data_o = {8'h00, sel_byte_s};
        end
    end

    // Store merge: replace only the addressed byte.
    always_comb begin
        merge_data_o = 16'h0000;
        if (lane_sel_i) begin
            merge_data_o = {rdata_i[15:8], wbyte_i};
        end else begin
            merge_data_o = {wbyte_i, rdata_i[7:0]};
        end
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one request at a time, word/byte accesses to a
// big-endian byte-addressed data memory, byte stores via read-modify-write.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int BYTE_SEXT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(MEM_BYTES - 1);

    lsu_state_e        state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_fault_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              we_q;
    logic              byte_q;
    logic              lane_q;
    logic [7:0]        wbyte_q;

    logic              accept_s;
    logic              fault_s;
    logic [DATA_W-1:0] lane_load_s;
    logic [DATA_W-1:0] lane_merge_s;
    logic [DATA_W-1:0] load_result_s;

    assign accept_s = req_valid & req_ready_q;
    assign fault_s  = access_fault(req_addr, req_byte, LAST_BYTE);

    lsu_byte_lane #(
        .BYTE_SEXT (BYTE_SEXT)
    ) u_byte_lane (
        .lane_sel_i   (lane_q),
        .rdata_i      (mem_rdata),
        .wbyte_i      (wbyte_q),
        .load_data_o  (lane_load_s),
        .merge_data_o (lane_merge_s)
    );

    // Load result: whole word or the extended byte lane.
    always_comb begin
        load_result_s = 16'h0000;
        if (byte_q) begin
            load_result_s = lane_load_s;
        end else begin
            load_result_s = mem_rdata;
        end
    end

    // Sequencer: state, latched request fields and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'h0000;
            resp_fault_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= 1'b0;
            wbyte_q      <= 8'h00;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 16'h0000;
            resp_fault_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        byte_q      <= req_byte;
                        lane_q      <= req_addr[0];
                        wbyte_q     <= req_wdata[7:0];
                        if (fault_s) begin
                            state_q <= RESP_FAULT;
                        end else if (req_we && !req_byte) begin
                            state_q     <= WR;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= align_addr(req_addr);
                            mem_wdata_q <= req_wdata;
                        end else begin
                            // Loads and byte stores both start with a read.
                            state_q    <= RD_ISSUE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= align_addr(req_addr);
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    state_q <= RD_CAPT;
                end
                RD_CAPT: begin
                    if (we_q) begin
                        state_q     <= WR;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= lane_merge_s;
                    end else begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_result_s;
                    end
                end
                WR: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b1;
                end
                RESP_FAULT: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
